// File: rtl/hxmpp_hitinfo_queue_if.sv
// Bus bundle for the HXMPP hit-info queue.
// master: the pipeline side that pushes, pops, flushes and observes status.
// slave : the queue itself.
// Signals: push/push_data/flush (per channel), pop/pop_chan, clear_err,
//          pop_data/pop_valid/pop_chan_out, empty/full/count, overflow/underflow.
interface hxmpp_hitinfo_queue_if #(
    parameter int unsigned NCHANNELS   = 2,
    parameter int unsigned CHANBITS    = 1,
    parameter int unsigned DEPTHBITS   = 3,
    parameter int unsigned HITINFOBITS = 8
);
    localparam int unsigned CNTW = DEPTHBITS + 1;

    logic [NCHANNELS-1:0]             push;
    logic [NCHANNELS*HITINFOBITS-1:0] push_data;
    logic                             pop;
    logic [CHANBITS-1:0]              pop_chan;
    logic [NCHANNELS-1:0]             flush;
    logic                             clear_err;

    logic [HITINFOBITS-1:0]           pop_data;
    logic                             pop_valid;
    logic [CHANBITS-1:0]              pop_chan_out;
    logic [NCHANNELS-1:0]             empty;
    logic [NCHANNELS-1:0]             full;
    logic [NCHANNELS*CNTW-1:0]        count;
    logic [NCHANNELS-1:0]             overflow;
    logic                             underflow;

    modport master (
        output push, push_data, pop, pop_chan, flush, clear_err,
        input  pop_data, pop_valid, pop_chan_out, empty, full, count,
               overflow, underflow
    );

    modport slave (
        input  push, push_data, pop, pop_chan, flush, clear_err,
        output pop_data, pop_valid, pop_chan_out, empty, full, count,
               overflow, underflow
    );
endinterface

// File: rtl/hxmpp_hitinfo_queue.sv
// Multi-channel hit-info queue: one circular buffer per channel holds hit-info
// words until HNM pops the matching channel; the word appears registered one
// cycle after the pop.
// Ports: clk, reset (synchronous, active-low), bus (slave side of
//        hxmpp_hitinfo_queue_if: push/pop/flush/clear_err in, popped word,
//        occupancy status and sticky error flags out).
module hxmpp_hitinfo_queue #(
    parameter int unsigned NCHANNELS   = 2,
    parameter int unsigned CHANBITS    = 1,
    parameter int unsigned DEPTH       = 8,
    parameter int unsigned DEPTHBITS   = 3,
    parameter int unsigned HITINFOBITS = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    hxmpp_hitinfo_queue_if.slave  bus
);
    localparam int unsigned CNTW = DEPTHBITS + 1;

    logic [HITINFOBITS-1:0] mem_q   [NCHANNELS][DEPTH];
    logic [HITINFOBITS-1:0] mem_d   [NCHANNELS][DEPTH];
    logic [DEPTHBITS-1:0]   wr_ptr_q [NCHANNELS];
    logic [DEPTHBITS-1:0]   wr_ptr_d [NCHANNELS];
    logic [DEPTHBITS-1:0]   rd_ptr_q [NCHANNELS];
    logic [DEPTHBITS-1:0]   rd_ptr_d [NCHANNELS];
    logic [CNTW-1:0]        count_q  [NCHANNELS];
    logic [CNTW-1:0]        count_d  [NCHANNELS];

    logic [HITINFOBITS-1:0] pop_data_q, pop_data_d;
    logic                   pop_valid_q, pop_valid_d;
    logic [CHANBITS-1:0]    pop_chan_out_q, pop_chan_out_d;
    logic [NCHANNELS-1:0]   overflow_q, overflow_d;
    logic                   underflow_q, underflow_d;

    logic [NCHANNELS-1:0]   pop_hit;
    logic [NCHANNELS-1:0]   pop_ok;
    logic [NCHANNELS-1:0]   push_ok;

    // Pointer increment with explicit wrap so DEPTH need not be a power of 2.
    function automatic logic [DEPTHBITS-1:0] ptr_inc(input logic [DEPTHBITS-1:0] p);
        return (p == DEPTHBITS'(DEPTH - 1)) ? '0 : p + DEPTHBITS'(1);
    endfunction

    // Next-state: per-channel push/pop/flush and pop output register.
    always_comb begin
        mem_d          = mem_q;
        wr_ptr_d       = wr_ptr_q;
        rd_ptr_d       = rd_ptr_q;
        count_d        = count_q;
        pop_valid_d    = 1'b0;
        pop_data_d     = pop_data_q;
        pop_chan_out_d = pop_chan_out_q;
        overflow_d     = bus.clear_err ? '0 : overflow_q;
        underflow_d    = bus.clear_err ? 1'b0 : underflow_q;
        pop_hit        = '0;
        pop_ok         = '0;
        push_ok        = '0;

        for (int c = 0; c < int'(NCHANNELS); c++) begin
            pop_hit[c] = bus.pop && (bus.pop_chan == CHANBITS'(c));
            // Occupancy is judged before this edge, so an empty channel never falls through.
            pop_ok[c]  = pop_hit[c] && !bus.flush[c] && (count_q[c] != '0);
            // A full channel still accepts a push when the same cycle frees a slot.
            push_ok[c] = bus.push[c] && !bus.flush[c] &&
                         ((count_q[c] != CNTW'(DEPTH)) || pop_ok[c]);

            if (bus.flush[c]) begin
                wr_ptr_d[c] = '0;
                rd_ptr_d[c] = '0;
                count_d[c]  = '0;
            end else begin
                if (pop_hit[c] && !pop_ok[c]) underflow_d = 1'b1;
                if (bus.push[c] && !push_ok[c]) overflow_d[c] = 1'b1;

                if (push_ok[c]) begin
                    mem_d[c][wr_ptr_q[c]] = bus.push_data[c*HITINFOBITS +: HITINFOBITS];
                    wr_ptr_d[c] = ptr_inc(wr_ptr_q[c]);
                end

                if (pop_ok[c]) begin
                    pop_valid_d    = 1'b1;
                    pop_data_d     = mem_q[c][rd_ptr_q[c]];
                    pop_chan_out_d = CHANBITS'(c);
                    rd_ptr_d[c]    = ptr_inc(rd_ptr_q[c]);
                end

                if (push_ok[c] && !pop_ok[c])      count_d[c] = count_q[c] + CNTW'(1);
                else if (pop_ok[c] && !push_ok[c]) count_d[c] = count_q[c] - CNTW'(1);
            end
        end

        // Channel index beyond the implemented lanes.
        if (bus.pop && (pop_hit == '0)) underflow_d = 1'b1;
    end

    // Control/status registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int c = 0; c < int'(NCHANNELS); c++) begin
                wr_ptr_q[c] <= '0;
                rd_ptr_q[c] <= '0;
                count_q[c]  <= '0;
            end
            pop_valid_q    <= 1'b0;
            pop_data_q     <= '0;
            pop_chan_out_q <= '0;
            overflow_q     <= '0;
            underflow_q    <= 1'b0;
        end else begin
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
            pop_valid_q    <= pop_valid_d;
            pop_data_q     <= pop_data_d;
            pop_chan_out_q <= pop_chan_out_d;
            overflow_q     <= overflow_d;
            underflow_q    <= underflow_d;
        end
    end

    // Storage array; contents are meaningless once pointers are reset.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    // Status is derived directly from the count registers.
    always_comb begin
        bus.count = '0;
        bus.empty = '0;
        bus.full  = '0;
        for (int c = 0; c < int'(NCHANNELS); c++) begin
            bus.count[c*CNTW +: CNTW] = count_q[c];
            bus.empty[c] = (count_q[c] == '0);
            bus.full[c]  = (count_q[c] == CNTW'(DEPTH));
        end
    end

    assign bus.pop_data     = pop_data_q;
    assign bus.pop_valid    = pop_valid_q;
    assign bus.pop_chan_out = pop_chan_out_q;
    assign bus.overflow     = overflow_q;
    assign bus.underflow    = underflow_q;
endmodule

// File: tb/tb_hxmpp_hitinfo_queue.sv
// Scoreboard bench for hxmpp_hitinfo_queue (2 channels, depth 4, 8-bit words).
module tb_hxmpp_hitinfo_queue;
    localparam int unsigned NCH = 2;
    localparam int unsigned CB  = 1;
    localparam int unsigned DP  = 4;
    localparam int unsigned DB  = 2;
    localparam int unsigned HB  = 8;

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    logic [8:0] sb[$];   // {chan, data} expected on each pop_valid

    hxmpp_hitinfo_queue_if #(.NCHANNELS(NCH), .CHANBITS(CB), .DEPTHBITS(DB),
                             .HITINFOBITS(HB)) bus ();

    hxmpp_hitinfo_queue #(.NCHANNELS(NCH), .CHANBITS(CB), .DEPTH(DP),
                          .DEPTHBITS(DB), .HITINFOBITS(HB)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Apply the currently driven inputs for one edge, then return inputs to idle.
    task automatic step();
        @(posedge clk);
        #1;
        bus.push      = '0;
        bus.pop       = 1'b0;
        bus.flush     = '0;
        bus.clear_err = 1'b0;
    endtask

    task automatic set_push(input int ch, input logic [7:0] d);
        bus.push[ch] = 1'b1;
        bus.push_data[ch*HB +: HB] = d;
    endtask

    task automatic set_pop(input int ch, input bit expect_ok, input logic [7:0] d);
        bus.pop      = 1'b1;
        bus.pop_chan = CB'(ch);
        if (expect_ok) sb.push_back({1'(ch), d});
    endtask

    task automatic push1(input int ch, input logic [7:0] d);
        set_push(ch, d);
        step();
    endtask

    task automatic pop1(input int ch, input logic [7:0] d);
        set_pop(ch, 1'b1, d);
        step();
    endtask

    // Monitor: every valid pop result must match the oldest expected entry.
    always @(negedge clk) begin
        if (bus.pop_valid === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pop actual=%0h/%0h required=none",
                         bus.pop_chan_out, bus.pop_data);
            end else begin
                logic [8:0] e;
                e = sb.pop_front();
                if ({bus.pop_chan_out, bus.pop_data} !== e) begin
                    errors++;
                    $display("FAIL pop_word actual=%0h/%0h required=%0h/%0h",
                             bus.pop_chan_out, bus.pop_data, e[8], e[7:0]);
                end
            end
        end
    end

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b0;
        bus.push = '0; bus.push_data = '0; bus.pop = 1'b0; bus.pop_chan = '0;
        bus.flush = '0; bus.clear_err = 1'b0;
        step(); step();
        reset = 1'b1;

        // Reset state
        chk("rst_empty", 32'(bus.empty), 32'h3);
        chk("rst_full", 32'(bus.full), 32'h0);
        chk("rst_count", 32'(bus.count), 32'h0);
        chk("rst_valid", 32'(bus.pop_valid), 32'h0);
        chk("rst_data", 32'(bus.pop_data), 32'h0);
        chk("rst_flags", 32'({bus.overflow, bus.underflow}), 32'h0);

        // Basic FIFO order on ch0
        push1(0, 8'h11); push1(0, 8'h22); push1(0, 8'h33);
        chk("ch0_count3", 32'(bus.count[2:0]), 32'd3);
        pop1(0, 8'h11); pop1(0, 8'h22); pop1(0, 8'h33);
        chk("ch0_count0", 32'(bus.count[2:0]), 32'd0);
        chk("ch0_empty", 32'(bus.empty[0]), 32'd1);

        // Overflow on ch1
        push1(1, 8'hA0); push1(1, 8'hA1); push1(1, 8'hA2); push1(1, 8'hA3);
        chk("ch1_full", 32'(bus.full[1]), 32'd1);
        chk("ch1_no_ovf_yet", 32'(bus.overflow), 32'h0);
        push1(1, 8'hA4);
        chk("ch1_overflow", 32'(bus.overflow), 32'h2);
        chk("ch1_count4", 32'(bus.count[5:3]), 32'd4);
        pop1(1, 8'hA0); pop1(1, 8'hA1); pop1(1, 8'hA2); pop1(1, 8'hA3);
        chk("ch1_empty", 32'(bus.empty), 32'h3);
        bus.clear_err = 1'b1; step();
        chk("ovf_cleared", 32'(bus.overflow), 32'h0);

        // Full ch0 with simultaneous push+pop, pointers wrap
        push1(0, 8'h41); push1(0, 8'h42); push1(0, 8'h43); push1(0, 8'h44);
        chk("ch0_full", 32'(bus.full[0]), 32'd1);
        set_push(0, 8'h55); set_pop(0, 1'b1, 8'h41); step();
        chk("ch0_pp_count", 32'(bus.count[2:0]), 32'd4);
        chk("ch0_pp_noovf", 32'(bus.overflow[0]), 32'd0);
        pop1(0, 8'h42); pop1(0, 8'h43); pop1(0, 8'h44); pop1(0, 8'h55);
        chk("ch0_drained", 32'(bus.count[2:0]), 32'd0);

        // Pop of empty ch1 with simultaneous push: no fall-through
        set_push(1, 8'h77); set_pop(1, 1'b0, 8'h00); step();
        chk("nofall_valid", 32'(bus.pop_valid), 32'd0);
        chk("nofall_underflow", 32'(bus.underflow), 32'd1);
        chk("nofall_count", 32'(bus.count[5:3]), 32'd1);
        bus.clear_err = 1'b1; step();
        chk("udf_cleared", 32'(bus.underflow), 32'd0);
        pop1(1, 8'h77);

        // Flush ch0 while popping it; ch1 untouched
        set_push(0, 8'h01); set_push(1, 8'h02); step();
        chk("dual_count", 32'(bus.count), 32'b001_001);
        bus.flush[0] = 1'b1; set_pop(0, 1'b0, 8'h00); step();
        chk("flush_count0", 32'(bus.count[2:0]), 32'd0);
        chk("flush_valid", 32'(bus.pop_valid), 32'd0);
        chk("flush_udf", 32'(bus.underflow), 32'd0);
        chk("flush_count1", 32'(bus.count[5:3]), 32'd1);
        pop1(1, 8'h02);
        chk("chan_out1", 32'(bus.pop_chan_out), 32'd1);

        // Reset mid-operation with a pop pending
        push1(0, 8'h61); push1(0, 8'h62); push1(0, 8'h63);
        chk("pre_rst_count", 32'(bus.count[2:0]), 32'd3);
        reset = 1'b0; set_pop(0, 1'b0, 8'h00); step();
        reset = 1'b1;
        chk("mrst_valid", 32'(bus.pop_valid), 32'd0);
        chk("mrst_data", 32'(bus.pop_data), 32'h0);
        chk("mrst_chan", 32'(bus.pop_chan_out), 32'h0);
        chk("mrst_empty", 32'(bus.empty), 32'h3);
        chk("mrst_count", 32'(bus.count), 32'h0);
        set_pop(0, 1'b0, 8'h00); step();
        chk("post_rst_udf", 32'(bus.underflow), 32'd1);
        chk("post_rst_valid", 32'(bus.pop_valid), 32'd0);

        step(); step();
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/hxmpp_hitinfo_queue.md
Name: hxmpp_hitinfo_queue

Overview:
- Parametrised, multi-channel hit-info queue for the HXMPP pipeline.
- Holds hit-info words written alongside SSIDs until HNM releases the matching SSID. It then presents the word, one cycle later, as the registered HCM hit-info input.
- Replaces the single shift-register queue with one circular buffer per channel, plus full/empty/count status, flush and sticky error flags.

Parameters:
- NCHANNELS, 2, number of independent input lanes/queues
- CHANBITS, 1, width of channel index (≥ clog2(NCHANNELS), min 1)
- DEPTH, 8, entries per channel queue (any value ≥ 2; need not be a power of 2)
- DEPTHBITS, 3, pointer width (clog2(DEPTH))
- HITINFOBITS, 8, hit-info word width

Ports:
- clk  in  1  clock, all logic on rising edge
- reset  in  1  synchronous, active-low reset
- push  in  NCHANNELS  per-channel write strobe
- push_data  in  NCHANNELS*HITINFOBITS  channel c occupies bits [c*HITINFOBITS +: HITINFOBITS]
- pop  in  1  pop request (driven by HNM newOutput)
- pop_chan  in  CHANBITS  channel to pop
- flush  in  NCHANNELS  per-channel queue clear
- clear_err  in  1  clears sticky error flags
- pop_data  out  HITINFOBITS  popped word, registered
- pop_valid  out  1  pop_data holds a valid popped word this cycle
- pop_chan_out  out  CHANBITS  channel of current pop_data
- empty  out  NCHANNELS  channel count == 0
- full  out  NCHANNELS  channel count == DEPTH
- count  out  NCHANNELS*(DEPTHBITS+1)  per-channel occupancy
- overflow  out  NCHANNELS  sticky: push dropped on full channel
- underflow  out  1  sticky: pop on empty channel or out-of-range pop_chan

Behaviour:
- Reset (reset==0 at a clk edge):
  - All pointers and counts go to 0.
  - empty = all 1; full = 0; count = 0.
  - pop_valid = 0; pop_data = 0; pop_chan_out = 0; overflow = 0; underflow = 0.
  - Reset has priority over every other input. Asserting it mid-operation discards all contents; no partial state survives.
- Storage: per channel, a DEPTH-entry array with wr_ptr, rd_ptr and count.
  - Pointers increment and wrap from DEPTH-1 to 0 by explicit compare, not modulo 2^DEPTHBITS.
- Push (channel c, push[c]==1):
  - If count<DEPTH, or a pop of c is accepted in the same cycle: write push_data[c] at wr_ptr and advance wr_ptr.
  - Otherwise drop the word, set overflow[c], and leave pointers unchanged.
- Pop (pop==1, channel c = pop_chan):
  - Accepted if c<NCHANNELS and count[c]>0 before this edge.
  - Next cycle: pop_data = mem[c][rd_ptr]; pop_valid = 1; pop_chan_out = c. rd_ptr advances.
  - Latency is exactly 1 cycle from pop to pop_valid.
  - No fall-through: a push to an empty channel in the same cycle as a pop of it is stored, the pop is rejected and underflow is set.
- Rejected or absent pop: pop_valid = 0 next cycle; pop_data and pop_chan_out hold their previous values.
- Count update:
  - accepted push only: +1
  - accepted pop only: −1
  - both: unchanged (also when full)
  - full and empty are derived combinationally from the count registers.
- Pushes on different channels in the same cycle are all independent.
- Flush[c]:
  - Sets c's pointers and count to 0 and overrides any push or pop on c in that cycle.
  - A pop of a flushed channel in that cycle gives pop_valid = 0 and does not set underflow.
  - Sticky flags are not cleared by flush.
- clear_err:
  - Clears overflow and underflow.
  - A new error in the same cycle wins, so the flag stays 1.
- Out-of-range pop_chan (≥ NCHANNELS): rejected and underflow is set.

Test Plan:
- NCHANNELS=2, DEPTH=4, HITINFOBITS=8. Reset, then push ch0 with 0x11,0x22,0x33 on three cycles, then pop ch0 three times back-to-back -> pop_valid=1 on the three cycles after each pop, pop_data 0x11,0x22,0x33, pop_chan_out=0; count[0] ends at 0 and empty[0]=1.
- Push ch1 with 0xA0..0xA4 (5 words) -> full[1]=1 after the 4th, 5th word dropped, overflow[1]=1; popping 4 returns 0xA0..0xA3.
- Fill ch0 to full (4 words), then push 0x55 and pop ch0 in the same cycle -> push accepted, count stays 4, overflow[0]=0; drain returns 0x55 last, exercising wrap-around.
- Pop ch1 while empty with a simultaneous push 0x77 -> pop_valid=0 next cycle, underflow=1, count[1]=1; clear_err -> underflow=0; a later pop returns 0x77.
- Push ch0 and ch1 in the same cycle (0x01/0x02), then flush[0] together with pop ch0 -> count[0]=0, pop_valid=0, underflow=0; count[1]=1 is unaffected.
- With 3 entries in ch0, drive reset=0 for one cycle, including while a pop is issued -> all outputs return to reset values, empty=2'b11, and the next pop of ch0 underflows.
